psum_accumulator: RTL and testbench
===================================

# psum_accumulator

Output stage placed directly downstream of the combinational dot-product unit. Each cycle it can take one signed `ACC_WIDTH` partial sum over a valid/ready handshake. It accumulates `NUM_TILES` consecutive partial sums onto a per-output bias, then requantizes the total to a signed `DATA_WIDTH` activation. The activation is presented on a valid/ready output port to the next layer's operand buffer.

## Interface
- `NUM_TILES`, 4: partial sums per output; legal range 1 to 2^16−1.
- `SHIFT`, 8: requantization right-shift; legal range 0 to `ACC_WIDTH`−1.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: `in_psum` carries a valid value.
- `in_ready`, out, 1: the block accepts `in_psum` this cycle.
- `in_psum`, in, `ACC_WIDTH`: signed partial sum from the dot-product unit.
- `bias`, in, `ACC_WIDTH`: signed bias, sampled only with the first tile of each output.
- `out_valid`, out, 1: `out_data` and `out_ovf` are valid.
- `out_ready`, in, 1: the consumer accepts the output.
- `out_data`, out, `DATA_WIDTH`: signed requantized activation.
- `out_ovf`, out, 1: saturation occurred somewhere while producing this output.

## Operation
- Widths come from the shared `DATA_WIDTH` and `ACC_WIDTH` macros.
- FSM states:
  - ACCUM: `in_ready` = 1, `out_valid` = 0.
  - OUTPUT: `out_valid` = 1, `in_ready` = `out_ready`.
- A tile is accepted when `in_valid && in_ready`.
- Tile counter `cnt` runs from 0 to `NUM_TILES`−1.
  - On accept with `cnt` == 0: `acc` ← `bias` + `in_psum`.
  - On any other accept: `acc` ← `acc` + `in_psum`.
- Every addition uses `ACC_WIDTH`+1 bits and is then saturated to the signed `ACC_WIDTH` range.
  - Any clamp sets the sticky `ovf_r` bit.
  - `ovf_r` clears when the first tile of the next output is accepted.
- On accept with `cnt` == `NUM_TILES`−1:
  - `cnt` ← 0.
  - Go to OUTPUT.
  - Register `out_data` = requant(final `acc`) and `out_ovf` = `ovf_r` | (clamps in this add) | (requant clamp).
- Requant procedure:
  - If `SHIFT` > 0, add 2^(`SHIFT`−1) as round-half-up, with saturation.
  - Arithmetic right shift by `SHIFT`.
  - Saturate to the range −2^(`DATA_WIDTH`−1) to 2^(`DATA_WIDTH`−1)−1.
- OUTPUT with `out_ready` = 0: hold `out_data` and `out_ovf` stable and accept no input.
- OUTPUT with `out_ready` = 1 and no accept: return to ACCUM.
- OUTPUT with `out_ready` = 1 and a tile accepted in the same cycle: the tile is the first tile of the next output (bias is loaded).
  - If `NUM_TILES` == 1, stay in OUTPUT and register the new result.
  - Otherwise go to ACCUM with `cnt` = 1.
- `in_psum` values presented while `in_ready` = 0 are ignored.

## Timing
- Reset values:
  - State ACCUM.
  - `cnt`, `acc` and `ovf_r` = 0.
  - `out_valid` = 0, `out_data` = 0, `out_ovf` = 0.
  - `in_ready` = 1 in the cycle after reset deasserts.
- Reset mid-accumulation or in OUTPUT discards the partial `acc` and the pending output, with no handshake completed.
- Latency: `out_valid` rises the cycle after the last tile is accepted.
- Full throughput is one tile per cycle and one output every `NUM_TILES` cycles, provided `out_ready` is high when the output is presented.
- `in_ready` in OUTPUT depends combinationally on `out_ready`. Every other output is driven from registers.

## Configuration
- `RELU_EN` defined: negative `acc` values are clamped to 0 before requantization.
  - A ReLU clamp does not set `out_ovf`.
- `RELU_EN` undefined: signed requantized output, with no ReLU logic synthesized.

## Structure
- Shared package `npu_pkg` holds:
  - the state enum `acc_state_t` with members ACCUM and OUTPUT;
  - saturation limit constants derived from `DATA_WIDTH` and `ACC_WIDTH`;
  - a `sat_add` function.
- Sub-module `requantize` is combinational and parameterized by `SHIFT`.
  - Inputs: `acc`.
  - Outputs: `data` and `clamp`.
  - Contains the rounding, shift, saturation and `RELU_EN` clamp.

## Test plan
Bench configuration: `DATA_WIDTH` 8, `ACC_WIDTH` 32, `NUM_TILES` 4, `SHIFT` 8, `out_ready` held at 1 unless stated.
- Bias 128 with psums 256, 512, −256, 0 → `out_data` = 3 and `out_ovf` = 0, one cycle after the fourth accept.
- Bias 0 with psums summing to 2^20 → `out_data` = 127 and `out_ovf` = 1; the next output with psums summing to 256 → `out_data` = 1 and `out_ovf` = 0.
- Bias 0 with psums summing to −1000:
  - `RELU_EN` undefined → `out_data` = −4 (round-half-up of −3.906).
  - `RELU_EN` defined → `out_data` = 0.
- `out_ready` held low for 3 cycles after a result → `out_valid` and `out_data` stable and `in_ready` = 0 for those cycles; no tile lost when `out_ready` rises together with `in_valid`.
- Two psums of 2^31−1 → the accumulator saturates at 2^31−1 and `out_ovf` = 1.
- `rst` asserted after 2 of 4 tiles, then 4 fresh tiles → the output reflects only the fresh tiles and the bias sampled after reset.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU types, saturation limits and the saturating adder.
// DATA_WIDTH / ACC_WIDTH macros default to 8 / 32 when not supplied by the build.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif

package npu_pkg;

    localparam int unsigned DW = `DATA_WIDTH;
    localparam int unsigned AW = `ACC_WIDTH;

    typedef enum logic {
        ACCUM,
        OUTPUT
    } acc_state_t;

    localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

    // Activation limits expressed at accumulator width for direct comparison.
    localparam logic signed [AW-1:0] DATA_MAX_ACC = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] DATA_MIN_ACC = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] DATA_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] DATA_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef struct packed {
        logic signed [AW-1:0] sum;
        logic                 clamp;
    } sat_t;

    function automatic sat_t sat_add(input logic signed [AW-1:0] a,
                                     input logic signed [AW-1:0] b);
        logic signed [AW:0] s;
        sat_t res;
        s = {a[AW-1], a} + {b[AW-1], b};
        res.clamp = s[AW] ^ s[AW-1];
        if (!res.clamp)
            res.sum = s[AW-1:0];
        else if (s[AW])
            res.sum = ACC_MIN;
        else
            res.sum = ACC_MAX;
        return res;
    endfunction

endpackage

// File: rtl/psum_accumulator_requantize.sv
// Combinational requantizer: round-half-up, arithmetic shift, saturate to DATA_WIDTH.
// Optional RELU_EN macro clamps negative accumulators to zero (not reported as a clamp).
module requantize
    import npu_pkg::*;
#(
    parameter int unsigned SHIFT = 8
) (
    input  logic signed [AW-1:0] acc,
    output logic signed [DW-1:0] data,
    output logic                 clamp
);

    logic signed [AW-1:0] v;
    logic signed [AW-1:0] r;
    logic signed [AW-1:0] sh;
    logic                 rclamp;

    always_comb begin
        v = acc;
`ifdef RELU_EN
        if (acc[AW-1])
            v = '0;
`endif
    end

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [AW-1:0] HALF = {{(AW-1){1'b0}}, 1'b1} << (SHIFT - 1);
            sat_t rs;
            assign rs     = sat_add(v, HALF);
            assign r      = rs.sum;
            assign rclamp = rs.clamp;
        end else begin : g_noround
            assign r      = v;
            assign rclamp = 1'b0;
        end
    endgenerate

    assign sh = r >>> SHIFT;

    always_comb begin
        data  = sh[DW-1:0];
        clamp = rclamp;
        if (sh > DATA_MAX_ACC) begin
            data  = DATA_MAX;
            clamp = 1'b1;
        end else if (sh < DATA_MIN_ACC) begin
            data  = DATA_MIN;
            clamp = 1'b1;
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates NUM_TILES partial sums onto a bias and emits a requantized activation.
// Optional feature macro: RELU_EN (handled inside requantize).
module psum_accumulator
    import npu_pkg::*;
#(
    parameter int unsigned NUM_TILES = 4,
    parameter int unsigned SHIFT     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [AW-1:0] in_psum,
    input  logic signed [AW-1:0] bias,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic                 out_ovf
);

    localparam logic [15:0] LAST = 16'(NUM_TILES - 1);

    acc_state_t           state, state_next;
    logic [15:0]          cnt;
    logic signed [AW-1:0] acc;
    logic                 ovf_r;

    logic                 accept;
    logic                 last;
    logic signed [AW-1:0] base;
    sat_t                 add;
    logic                 ovf_sum;
    logic signed [DW-1:0] rq_data;
    logic                 rq_clamp;

    assign in_ready  = (state == ACCUM) | out_ready;
    assign out_valid = (state == OUTPUT);
    assign accept    = in_valid & in_ready;
    assign last      = (cnt == LAST);

    // cnt is always 0 in OUTPUT, so an accept there naturally loads the bias.
    always_comb begin
        base    = (cnt == '0) ? bias : acc;
        add     = sat_add(base, in_psum);
        ovf_sum = ((cnt == '0) ? 1'b0 : ovf_r) | add.clamp;
    end

    requantize #(.SHIFT(SHIFT)) u_requantize (
        .acc   (add.sum),
        .data  (rq_data),
        .clamp (rq_clamp)
    );

    always_comb begin
        state_next = state;
        case (state)
            ACCUM: begin
                if (accept && last)
                    state_next = OUTPUT;
            end
            OUTPUT: begin
                if (out_ready)
                    state_next = (accept && last) ? OUTPUT : ACCUM;
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ACCUM;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            acc      <= '0;
            ovf_r    <= 1'b0;
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else if (accept) begin
            acc   <= add.sum;
            ovf_r <= ovf_sum;
            if (last) begin
                cnt      <= '0;
                out_data <= rq_data;
                out_ovf  <= ovf_sum | rq_clamp;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed self-checking bench for psum_accumulator (NUM_TILES 4, SHIFT 8, 8/32-bit widths).
module tb_psum_accumulator;
    import npu_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [AW-1:0] in_psum;
    logic signed [AW-1:0] bias;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_data;
    logic                 out_ovf;

    int total = 0;
    int bad   = 0;

    psum_accumulator #(.NUM_TILES(4), .SHIFT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_psum   (in_psum),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_tile(input logic signed [AW-1:0] p, input logic signed [AW-1:0] b);
        in_valid = 1'b1;
        in_psum  = p;
        bias     = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_psum = '0; bias = '0; out_ready = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
        total++; if (out_data !== 8'sd0) begin bad++; $display("FAIL reset_data got=%0d want=0", out_data); end
        total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b want=0", out_ovf); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    endtask

    task automatic test_basic();
        drive_tile(256, 128);
        drive_tile(512, 999);
        drive_tile(-256, -999);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%0b want=0", out_valid); end
        drive_tile(0, 77);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b want=1", out_valid); end
        total++; if (out_data !== 8'sd3) begin bad++; $display("FAIL basic_data got=%0d want=3", out_data); end
        total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%0b want=0", out_ovf); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drop got=%0b want=0", out_valid); end
    endtask

    // Second output starts in the same cycle the first one is consumed.
    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) drive_tile(32'sd262144, 0);
        total++; if (out_data !== 8'sd127) begin bad++; $display("FAIL sat_data got=%0d want=127", out_data); end
        total++; if (out_ovf !== 1'b1) begin bad++; $display("FAIL sat_ovf got=%0b want=1", out_ovf); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%0b want=1", in_ready); end
        drive_tile(64, 0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid got=%0b want=0", out_valid); end
        for (int i = 0; i < 3; i++) drive_tile(64, 5000);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid2 got=%0b want=1", out_valid); end
        total++; if (out_data !== 8'sd1) begin bad++; $display("FAIL b2b_data got=%0d want=1", out_data); end
        total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL b2b_ovf got=%0b want=0", out_ovf); end
        tick();
    endtask

    task automatic test_negative();
        logic signed [DW-1:0] want;
`ifdef RELU_EN
        want = 8'sd0;
`else
        want = -8'sd4;
`endif
        for (int i = 0; i < 4; i++) drive_tile(-250, 0);
        total++; if (out_data !== want) begin bad++; $display("FAIL neg_data got=%0d want=%0d", out_data, want); end
        total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL neg_ovf got=%0b want=0", out_ovf); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) drive_tile(512, 0);
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_psum = 10000; bias = 10000;
            #1;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid c=%0d got=%0b want=1", c, out_valid); end
            total++; if (out_data !== 8'sd8) begin bad++; $display("FAIL bp_data c=%0d got=%0d want=8", c, out_data); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready c=%0d got=%0b want=0", c, in_ready); end
            tick();
        end
        out_ready = 1'b1;
        in_psum = 256; bias = 256;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%0b want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) drive_tile(256, -7777);
        total++; if (out_data !== 8'sd5) begin bad++; $display("FAIL bp_next_data got=%0d want=5", out_data); end
        total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL bp_next_ovf got=%0b want=0", out_ovf); end
        tick();
    endtask

    task automatic test_acc_saturation();
        drive_tile(32'sh7fffffff, 0);
        drive_tile(32'sh7fffffff, 0);
        total++; if (dut.acc !== 32'sh7fffffff) begin bad++; $display("FAIL accsat_acc got=%0d want=2147483647", dut.acc); end
        drive_tile(0, 0);
        drive_tile(0, 0);
        total++; if (out_data !== 8'sd127) begin bad++; $display("FAIL accsat_data got=%0d want=127", out_data); end
        total++; if (out_ovf !== 1'b1) begin bad++; $display("FAIL accsat_ovf got=%0b want=1", out_ovf); end
        tick();
    endtask

    task automatic test_reset_mid();
        drive_tile(5000, 1000);
        drive_tile(5000, 1000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%0b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%0b want=1", in_ready); end
        drive_tile(256, -128);
        drive_tile(256, 3000);
        drive_tile(0, 3000);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_early got=%0b want=0", out_valid); end
        drive_tile(0, 3000);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_valid2 got=%0b want=1", out_valid); end
        total++; if (out_data !== 8'sd2) begin bad++; $display("FAIL rstmid_data got=%0d want=2", out_data); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_negative();
        test_backpressure();
        test_acc_saturation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
